// File: rtl/dot_prod_host.sv
// Host-side driver for the dot-product kernel: loads operand pairs into the kernel arrays,
// kicks the kernel, waits for completion (with a watchdog) and returns the result.
module dot_prod_host #(
   parameter int DEPTH   = 1000,
   parameter int ADDR_W  = 10,
   parameter int DATA_W  = 27,
   parameter int RES_W   = 64,
   parameter int TIMEOUT = 8192
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W:0]   cfg_len,
   input  logic [RES_W-1:0]  cfg_acc,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [RES_W-1:0]  res_data,
   output logic              res_err,
   output logic              busy,
   output logic              cfg_err,
   output logic              k_r_enable,
   output logic [ADDR_W-1:0] k_init_i,
   output logic [RES_W-1:0]  k_init_acc,
   output logic              k_ctrl,
   output logic              k_wen_a,
   output logic              k_wen_b,
   output logic [ADDR_W-1:0] k_addr_a,
   output logic [ADDR_W-1:0] k_addr_b,
   output logic [DATA_W-1:0] k_wdata_a,
   output logic [DATA_W-1:0] k_wdata_b,
   input  logic              k_w_enable,
   input  logic [RES_W-1:0]  k_result
);

   // Handshakes: a beat transfers on any cycle where valid && ready are both high at the
   // rising clock edge; the producer holds valid and payload stable until that edge.

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LOAD = 3'd1;
   localparam logic [2:0] S_KICK = 3'd2;
   localparam logic [2:0] S_RUN  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   localparam int            WD_W    = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   logic [2:0]        state;
   logic [ADDR_W-1:0] base;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W:0]   beats_left;
   logic [RES_W-1:0]  acc;
   logic [WD_W-1:0]   wd_cnt;
   logic              run_first;
   logic              beat;
   logic [ADDR_W:0]   depth_n;
   logic [ADDR_W:0]   base_calc;

   // Data is packed against the top of the array so the kernel's i==DEPTH bound stops after n terms.
   assign depth_n   = (ADDR_W + 1)'(DEPTH);
   assign base_calc = depth_n - cfg_len;

   assign in_ready   = (state == S_LOAD);
   assign beat       = in_ready & in_valid;
   assign k_ctrl     = (state == S_LOAD) || (state == S_KICK);
   assign k_r_enable = (state == S_KICK);
   assign k_init_i   = (state == S_KICK) ? base : '0;
   assign k_init_acc = (state == S_KICK) ? acc : '0;
   assign res_valid  = (state == S_DONE);
   assign busy       = (state != S_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         base       <= '0;
         wr_ptr     <= '0;
         beats_left <= '0;
         acc        <= '0;
         wd_cnt     <= '0;
         run_first  <= 1'b0;
         res_data   <= '0;
         res_err    <= 1'b0;
         cfg_err    <= 1'b0;
         k_wen_a    <= 1'b0;
         k_wen_b    <= 1'b0;
         k_addr_a   <= '0;
         k_addr_b   <= '0;
         k_wdata_a  <= '0;
         k_wdata_b  <= '0;
      end else begin
         cfg_err <= 1'b0;
         k_wen_a <= 1'b0;
         k_wen_b <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (cfg_len > depth_n) begin
                     cfg_err <= 1'b1;
                  end else if (cfg_len == '0) begin
                     res_data <= cfg_acc;
                     res_err  <= 1'b0;
                     state    <= S_DONE;
                  end else begin
                     beats_left <= cfg_len;
                     base       <= base_calc[ADDR_W-1:0];
                     wr_ptr     <= base_calc[ADDR_W-1:0];
                     acc        <= cfg_acc;
                     state      <= S_LOAD;
                  end
               end
            end
            S_LOAD: begin
               if (beat) begin
                  k_wen_a    <= 1'b1;
                  k_wen_b    <= 1'b1;
                  k_addr_a   <= wr_ptr;
                  k_addr_b   <= wr_ptr;
                  k_wdata_a  <= in_a;
                  k_wdata_b  <= in_b;
                  wr_ptr     <= wr_ptr + ADDR_W'(1);
                  beats_left <= beats_left - (ADDR_W + 1)'(1);
                  if (beats_left == (ADDR_W + 1)'(1)) state <= S_KICK;
               end
            end
            S_KICK: begin
               wd_cnt    <= '0;
               run_first <= 1'b1;
               state     <= S_RUN;
            end
            S_RUN: begin
               // The kernel's done flag is stale in the first RUN cycle, so it is not trusted there.
               run_first <= 1'b0;
               wd_cnt    <= wd_cnt + WD_W'(1);
               if (k_w_enable && !run_first) begin
                  res_data <= k_result;
                  res_err  <= 1'b0;
                  state    <= S_DONE;
               end else if (wd_cnt == WD_LAST) begin
                  res_data <= '0;
                  res_err  <= 1'b1;
                  state    <= S_DONE;
               end
            end
            S_DONE: begin
               if (res_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dot_prod_host.sv
// Directed bench for dot_prod_host with a behavioural model of the dot-product kernel.
module tb_dot_prod_host;
   localparam int DEPTH = 1000, ADDR_W = 10, DATA_W = 27, RES_W = 64, TIMEOUT = 8192;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [ADDR_W:0]   cfg_len = '0;
   logic [RES_W-1:0]  cfg_acc = '0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [DATA_W-1:0] in_a = '0, in_b = '0;
   logic              res_valid;
   logic              res_ready = 1'b0;
   logic [RES_W-1:0]  res_data;
   logic              res_err, busy, cfg_err, k_r_enable, k_ctrl, k_wen_a, k_wen_b;
   logic [ADDR_W-1:0] k_init_i, k_addr_a, k_addr_b;
   logic [RES_W-1:0]  k_init_acc;
   logic [DATA_W-1:0] k_wdata_a, k_wdata_b;
   logic              k_w_enable = 1'b0;
   logic [RES_W-1:0]  k_result = '0;

   int vec_cnt = 0;
   int err_cnt = 0;

   always #5 clk = ~clk;

   dot_prod_host #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RES_W(RES_W),
                   .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len), .cfg_acc(cfg_acc),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
      .busy(busy), .cfg_err(cfg_err), .k_r_enable(k_r_enable), .k_init_i(k_init_i),
      .k_init_acc(k_init_acc), .k_ctrl(k_ctrl), .k_wen_a(k_wen_a), .k_wen_b(k_wen_b),
      .k_addr_a(k_addr_a), .k_addr_b(k_addr_b), .k_wdata_a(k_wdata_a), .k_wdata_b(k_wdata_b),
      .k_w_enable(k_w_enable), .k_result(k_result)
   );

   // Kernel model: arrays written while controlArr=1; loop acc += a[i]*b[i] until i==DEPTH.
   logic signed [DATA_W-1:0] ka [DEPTH];
   logic signed [DATA_W-1:0] kb [DEPTH];
   int                       ki = 0;
   logic signed [RES_W-1:0]  kacc = '0;
   bit                       krun = 1'b0;
   bit                       k_hang = 1'b0;

   always @(posedge clk) begin
      if (k_ctrl && k_wen_a) ka[k_addr_a] <= k_wdata_a;
      if (k_ctrl && k_wen_b) kb[k_addr_b] <= k_wdata_b;
      if (k_r_enable) begin
         ki         <= int'(k_init_i);
         kacc       <= k_init_acc;
         k_w_enable <= 1'b0;
         krun       <= 1'b1;
      end else if (krun && !k_ctrl) begin
         if (ki < DEPTH) begin
            kacc <= kacc + longint'(ka[ki]) * longint'(kb[ki]);
            ki   <= ki + 1;
         end else if (!k_hang) begin
            k_w_enable <= 1'b1;
            k_result   <= kacc;
            krun       <= 1'b0;
         end
      end
   end

   // Monitor of kernel-side activity
   int                kick_cnt = 0;
   int                wen_cnt = 0;
   logic [ADDR_W-1:0] addr_log[$];
   logic [ADDR_W-1:0] init_i_seen = '0;
   always @(posedge clk) begin
      if (k_wen_a) begin
         wen_cnt++;
         addr_log.push_back(k_addr_a);
      end
      if (k_r_enable) begin
         kick_cnt++;
         init_i_seen = k_init_i;
      end
   end

   logic signed [DATA_W-1:0] va [DEPTH];
   logic signed [DATA_W-1:0] vb [DEPTH];
   logic [ADDR_W-1:0]        exp_q[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one job, returns result, wait cycles and cycles from KICK to res_valid.
   task automatic run_job(input int n, input logic [RES_W-1:0] acc, input bit gaps,
                          input int stall, input bit poke_start, output logic [RES_W-1:0] rdata,
                          output logic rerr, output int wait_cyc, output int lat_kick);
      int  i, budget;
      bit  stable, err_seen;
      start   = 1'b1;
      cfg_len = (ADDR_W + 1)'(n);
      cfg_acc = acc;
      tick();
      start = 1'b0;
      i = 0;
      budget = 0;
      while (i < n && budget < 20000) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
         end else begin
            in_valid = 1'b1;
            in_a = va[i];
            in_b = vb[i];
         end
         if (in_valid && in_ready) i++;
         tick();
         budget++;
      end
      in_valid = 1'b0;
      vec_cnt++;
      if (i !== n) begin
         err_cnt++;
         $display("FAIL load_beats: accepted %0d required %0d", i, n);
      end
      budget = 0;
      lat_kick = -1;
      while (!res_valid && budget < 12000) begin
         if (k_r_enable) lat_kick = 0;
         else if (lat_kick >= 0) lat_kick++;
         tick();
         budget++;
      end
      wait_cyc = budget;
      vec_cnt++;
      if (res_valid !== 1'b1) begin
         err_cnt++;
         $display("FAIL res_wait: res_valid never rose within %0d cycles", budget);
      end
      rdata = res_data;
      rerr = res_err;
      stable = 1'b1;
      err_seen = 1'b0;
      for (int s = 0; s < stall; s++) begin
         if (poke_start) begin
            start = 1'b1;
            cfg_len = (ADDR_W + 1)'(DEPTH + 1);
         end
         tick();
         if (cfg_err) err_seen = 1'b1;
         if (res_valid !== 1'b1 || res_data !== rdata || res_err !== rerr) stable = 1'b0;
      end
      start = 1'b0;
      if (stall > 0) begin
         vec_cnt++;
         if (stable !== 1'b1 || err_seen !== 1'b0) begin
            err_cnt++;
            $display("FAIL stall_hold: stable=%0b cfg_err_seen=%0b required 1/0", stable, err_seen);
         end
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      vec_cnt++;
      if ({res_valid, busy} !== 2'b00) begin
         err_cnt++;
         $display("FAIL handshake: res_valid,busy=%b required 00", {res_valid, busy});
      end
   endtask

   task automatic test_reset();
      #2;
      vec_cnt++;
      if ({busy, in_ready, res_valid, res_err, cfg_err, k_r_enable, k_ctrl, k_wen_a, k_wen_b} !== 9'b0
          || res_data !== '0 || k_addr_a !== '0 || k_wdata_a !== '0 || k_init_acc !== '0) begin
         err_cnt++;
         $display("FAIL reset_outputs: some output nonzero during reset (busy=%b res_data=%h)",
                  busy, res_data);
      end
      #21 rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      logic [RES_W-1:0] d; logic e; int w, l;
      va[0] = 1; va[1] = 2; va[2] = 3;
      vb[0] = 4; vb[1] = 5; vb[2] = 6;
      addr_log.delete();
      run_job(3, 64'd0, 1'b0, 0, 1'b0, d, e, w, l);
      vec_cnt++;
      if (d !== 64'd32 || e !== 1'b0) begin
         err_cnt++;
         $display("FAIL basic_result: got %0d err=%0b required 32 err=0", d, e);
      end
      exp_q = '{10'd997, 10'd998, 10'd999};
      vec_cnt++;
      if (addr_log !== exp_q) begin
         err_cnt++;
         $display("FAIL basic_addrs: got %p required %p", addr_log, exp_q);
      end
      vec_cnt++;
      if (init_i_seen !== 10'd997) begin
         err_cnt++;
         $display("FAIL basic_init_i: got %0d required 997", init_i_seen);
      end
   endtask

   task automatic test_sign_ext();
      logic [RES_W-1:0] d; logic e; int w, l;
      va[0] = -27'sd67108864;
      vb[0] = -27'sd67108864;
      run_job(1, {RES_W{1'b1}}, 1'b0, 0, 1'b0, d, e, w, l);
      vec_cnt++;
      if (d !== 64'd4503599627370495 || e !== 1'b0) begin
         err_cnt++;
         $display("FAIL sign_ext: got %0d err=%0b required 4503599627370495 err=0", d, e);
      end
   endtask

   task automatic test_zero_len();
      logic [RES_W-1:0] d; logic e; int w, l, k0;
      k0 = kick_cnt;
      run_job(0, 64'd7, 1'b0, 0, 1'b0, d, e, w, l);
      vec_cnt++;
      if (d !== 64'd7 || e !== 1'b0 || w > 1) begin
         err_cnt++;
         $display("FAIL zero_len: got %0d err=%0b wait=%0d required 7 err=0 wait<=1", d, e, w);
      end
      vec_cnt++;
      if (kick_cnt !== k0) begin
         err_cnt++;
         $display("FAIL zero_len_kick: kicks %0d required %0d", kick_cnt, k0);
      end
   endtask

   task automatic test_full_stall();
      logic [RES_W-1:0] d; logic e; int w, l;
      for (int i = 0; i < DEPTH; i++) begin
         va[i] = 1;
         vb[i] = 1;
      end
      run_job(DEPTH, 64'd0, 1'b1, 20, 1'b1, d, e, w, l);
      vec_cnt++;
      if (d !== 64'd1000 || e !== 1'b0) begin
         err_cnt++;
         $display("FAIL full_depth: got %0d err=%0b required 1000 err=0", d, e);
      end
   endtask

   task automatic test_cfg_err();
      int k0, w0;
      k0 = kick_cnt;
      w0 = wen_cnt;
      start = 1'b1;
      cfg_len = (ADDR_W + 1)'(DEPTH + 1);
      tick();
      start = 1'b0;
      vec_cnt++;
      if ({cfg_err, busy} !== 2'b10) begin
         err_cnt++;
         $display("FAIL cfg_err_pulse: cfg_err,busy=%b required 10", {cfg_err, busy});
      end
      tick();
      tick();
      vec_cnt++;
      if ({cfg_err, busy} !== 2'b00 || kick_cnt !== k0 || wen_cnt !== w0) begin
         err_cnt++;
         $display("FAIL cfg_err_after: cfg_err,busy=%b kicks=%0d writes=%0d required 00/%0d/%0d",
                  {cfg_err, busy}, kick_cnt, wen_cnt, k0, w0);
      end
   endtask

   task automatic test_timeout();
      logic [RES_W-1:0] d; logic e; int w, l;
      va[0] = 5;
      vb[0] = 5;
      k_hang = 1'b1;
      run_job(1, 64'd9, 1'b0, 0, 1'b0, d, e, w, l);
      k_hang = 1'b0;
      vec_cnt++;
      if (d !== 64'd0 || e !== 1'b1 || l !== TIMEOUT) begin
         err_cnt++;
         $display("FAIL timeout: got %0d err=%0b lat=%0d required 0 err=1 lat=%0d", d, e, l, TIMEOUT);
      end
   endtask

   task automatic test_reset_mid_run();
      logic [RES_W-1:0] d; logic e; int w, l, budget;
      start = 1'b1;
      cfg_len = 11'd3;
      cfg_acc = 64'd0;
      tick();
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_a = 27'd9;
         in_b = 27'd9;
         tick();
      end
      in_valid = 1'b0;
      budget = 0;
      while (!k_r_enable && budget < 10) begin
         tick();
         budget++;
      end
      tick();
      #2 rst_n = 1'b0;
      #1;
      vec_cnt++;
      if ({busy, in_ready, res_valid, res_err, k_r_enable, k_ctrl, k_wen_a, k_wen_b} !== 8'b0
          || res_data !== '0) begin
         err_cnt++;
         $display("FAIL async_reset: busy=%b ctrl=%b r_en=%b res_data=%h required all 0",
                  busy, k_ctrl, k_r_enable, res_data);
      end
      #3 rst_n = 1'b1;
      tick();
      va[0] = 3; va[1] = 3;
      vb[0] = 2; vb[1] = 2;
      run_job(2, 64'd0, 1'b0, 0, 1'b0, d, e, w, l);
      vec_cnt++;
      if (d !== 64'd12 || e !== 1'b0) begin
         err_cnt++;
         $display("FAIL after_reset_job: got %0d err=%0b required 12 err=0", d, e);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_sign_ext();
      test_zero_len();
      test_full_stall();
      test_cfg_err();
      test_timeout();
      test_reset_mid_run();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
